mram_responder: RTL and testbench

Synthesizable responder for the MRAM parallel bus. It decodes active-low chip/write/output/byte-enable strobes plus a 20-bit address and 16-bit data word, and services reads and writes against an internal byte-enabled array. It sits on the memory side of the bus, opposite the FPGA-side MRAM control/serializer path. The team uses it as an on-chip stand-in for the physical MRAM during bring-up and closed-loop regression.

---
 rtl/mram_responder_pkg.sv | 25 ++
 rtl/mram_byte_array.sv | 26 ++
 rtl/mram_responder.sv | 155 +++++++++++++++
 tb/tb_mram_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mram_responder_pkg.sv
// Shared definitions for the MRAM bus responder and the FPGA-side controller:
// FSM encodings, default bus widths, strobe levels and lane masking.
package mram_responder_pkg;

   localparam int ADDR_W_DEF = 20;
   localparam int DATA_W_DEF = 16;

   localparam logic STROBE_ON  = 1'b0;
   localparam logic STROBE_OFF = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WR_HOLD  = 2'd1,
      ST_RD_WAIT  = 2'd2,
      ST_RD_DRIVE = 2'd3
   } state_t;

   // A disabled lane reads back as zero.
   function automatic logic [15:0] mask_word(input logic [15:0] word,
                                             input logic lo_on,
                                             input logic hi_on);
      return {hi_on ? word[15:8] : 8'h00, lo_on ? word[7:0] : 8'h00};
   endfunction

endpackage

// File: rtl/mram_byte_array.sv
// Two-lane synchronous RAM with independent lane write enables and a
// registered read port. Contents are not reset.
module mram_byte_array #(
   parameter int MEM_ADDR_W = 8
) (
   input  logic                  clk,
   input  logic [MEM_ADDR_W-1:0] wr_addr,
   input  logic [15:0]           wr_data,
   input  logic                  wr_lo,
   input  logic                  wr_hi,
   input  logic [MEM_ADDR_W-1:0] rd_addr,
   output logic [15:0]           rd_data
);

   localparam int DEPTH = 2 ** MEM_ADDR_W;

   logic [7:0] mem_lo [DEPTH];
   logic [7:0] mem_hi [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_lo) mem_lo[wr_addr] <= wr_data[7:0];
      if (wr_hi) mem_hi[wr_addr] <= wr_data[15:8];
      rd_data <= {mem_hi[rd_addr], mem_lo[rd_addr]};
   end

endmodule

// File: rtl/mram_responder.sv
// Memory-side responder for the MRAM parallel bus: decodes the active-low
// strobes and services byte-enabled reads and writes against an on-chip array.
//
// state       | meaning
// ST_IDLE     | waiting for a request; writes commit here
// ST_WR_HOLD  | write done, waiting for chip_en release
// ST_RD_WAIT  | read latched, counting down the read latency
// ST_RD_DRIVE | driving masked read data with data_out_valid
module mram_responder
   import mram_responder_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int MEM_ADDR_W = 8,
   parameter int READ_LAT   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              chip_en,
   input  logic              write_en,
   input  logic              out_en,
   input  logic              lower_byte_en,
   input  logic              upper_byte_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_out_valid,
   output logic              bus_conflict,
   output logic [7:0]        err_count
);

   localparam int CNT_W = 2;

   state_t                state, state_n;
   logic [CNT_W-1:0]      cnt, cnt_n;
   logic [MEM_ADDR_W-1:0] addr_q, addr_n;
   logic                  lo_q, lo_n, hi_q, hi_n;
   logic [DATA_W-1:0]     dout_n;
   logic                  valid_n, conflict_n;
   logic                  wr_lo, wr_hi;
   logic [MEM_ADDR_W-1:0] rd_addr;
   logic [15:0]           rd_data;

   logic chip_on, wr_on, out_on, lo_on, hi_on;
   logic wr_req, rd_req, conflict;
   logic unused_addr_hi;

   assign chip_on = (chip_en == STROBE_ON);
   assign wr_on   = (write_en == STROBE_ON);
   assign out_on  = (out_en == STROBE_ON);
   assign lo_on   = (lower_byte_en == STROBE_ON);
   assign hi_on   = (upper_byte_en == STROBE_ON);

   assign wr_req   = chip_on & wr_on & ~out_on;
   assign rd_req   = chip_on & ~wr_on & out_on;
   assign conflict = chip_on & wr_on & out_on;

   assign unused_addr_hi = ^addr[ADDR_W-1:MEM_ADDR_W];

   mram_byte_array #(.MEM_ADDR_W(MEM_ADDR_W)) u_array (
      .clk     (clk),
      .wr_addr (addr[MEM_ADDR_W-1:0]),
      .wr_data (data_in),
      .wr_lo   (wr_lo),
      .wr_hi   (wr_hi),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      addr_n     = addr_q;
      lo_n       = lo_q;
      hi_n       = hi_q;
      dout_n     = data_out;
      valid_n    = data_out_valid;
      conflict_n = 1'b0;
      wr_lo      = 1'b0;
      wr_hi      = 1'b0;
      rd_addr    = addr_q;

      // A conflict in any state is counted and returns the FSM to idle.
      if (conflict) begin
         conflict_n = 1'b1;
         state_n    = ST_IDLE;
         dout_n     = '0;
         valid_n    = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (wr_req) begin
                  wr_lo   = lo_on & ~rst;
                  wr_hi   = hi_on & ~rst;
                  state_n = ST_WR_HOLD;
               end else if (rd_req) begin
                  addr_n  = addr[MEM_ADDR_W-1:0];
                  lo_n    = lo_on;
                  hi_n    = hi_on;
                  cnt_n   = CNT_W'(READ_LAT - 1);
                  rd_addr = addr[MEM_ADDR_W-1:0];
                  state_n = ST_RD_WAIT;
               end
            end
            ST_WR_HOLD: begin
               if (!chip_on) state_n = ST_IDLE;
            end
            ST_RD_WAIT: begin
               if (!chip_on || !out_on) begin
                  state_n = ST_IDLE;
               end else if (cnt == '0) begin
                  dout_n  = mask_word(rd_data, lo_q, hi_q);
                  valid_n = 1'b1;
                  state_n = ST_RD_DRIVE;
               end else begin
                  cnt_n = cnt - 1'b1;
               end
            end
            ST_RD_DRIVE: begin
               if (!chip_on || !out_on) begin
                  dout_n  = '0;
                  valid_n = 1'b0;
                  state_n = ST_IDLE;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         addr_q         <= '0;
         lo_q           <= 1'b0;
         hi_q           <= 1'b0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         bus_conflict   <= 1'b0;
         err_count      <= 8'h00;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         addr_q         <= addr_n;
         lo_q           <= lo_n;
         hi_q           <= hi_n;
         data_out       <= dout_n;
         data_out_valid <= valid_n;
         bus_conflict   <= conflict_n;
         if (conflict_n && err_count != 8'hFF) err_count <= err_count + 8'h01;
      end
   end

endmodule

// File: tb/tb_mram_responder.sv
// Directed bench for mram_responder: per-cycle vector table plus hand-written
// sequences for saturation and reset during a read.
module tb_mram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        chip_en, write_en, out_en, lower_byte_en, upper_byte_en;
   logic [19:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        data_out_valid;
   logic        bus_conflict;
   logic [7:0]  err_count;

   int checks = 0;
   int errors = 0;

   // strobes packed as {chip_en, write_en, out_en, lower_byte_en, upper_byte_en}
   localparam logic [4:0] NOP     = 5'b11111;
   localparam logic [4:0] WR_BOTH = 5'b00100;
   localparam logic [4:0] WR_UP   = 5'b00110;
   localparam logic [4:0] WR_NONE = 5'b00111;
   localparam logic [4:0] RD_BOTH = 5'b01000;
   localparam logic [4:0] RD_LO   = 5'b01001;
   localparam logic [4:0] RD_NONE = 5'b01011;
   localparam logic [4:0] RD_REL  = 5'b01100;
   localparam logic [4:0] CONF    = 5'b00000;

   typedef struct {
      logic [4:0]  strb;
      logic [19:0] addr;
      logic [15:0] din;
      logic [15:0] dout;
      logic        valid;
      logic        conf;
      logic [7:0]  err;
   } vec_t;

   vec_t vecs[$];

   mram_responder dut (
      .clk            (clk),
      .rst            (rst),
      .chip_en        (chip_en),
      .write_en       (write_en),
      .out_en         (out_en),
      .lower_byte_en  (lower_byte_en),
      .upper_byte_en  (upper_byte_en),
      .addr           (addr),
      .data_in        (data_in),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .bus_conflict   (bus_conflict),
      .err_count      (err_count)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [4:0] strb, input logic [19:0] a,
                               input logic [15:0] din, input logic [15:0] dout,
                               input logic valid, input logic conf,
                               input logic [7:0] err);
      vec_t v;
      v.strb = strb; v.addr = a; v.din = din;
      v.dout = dout; v.valid = valid; v.conf = conf; v.err = err;
      return v;
   endfunction

   task automatic drive(input logic [4:0] strb, input logic [19:0] a,
                        input logic [15:0] din);
      {chip_en, write_en, out_en, lower_byte_en, upper_byte_en} = strb;
      addr    = a;
      data_in = din;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [15:0] dout,
                          input logic valid, input logic conf,
                          input logic [7:0] err);
      chk({tag, " data_out"}, data_out, dout);
      chk({tag, " valid"}, {15'd0, data_out_valid}, {15'd0, valid});
      chk({tag, " bus_conflict"}, {15'd0, bus_conflict}, {15'd0, conf});
      chk({tag, " err_count"}, {8'd0, err_count}, {8'd0, err});
   endtask

   initial begin
      // full write then read, valid exactly two edges after capture
      vecs.push_back(mk(WR_BOTH, 20'h00012, 16'hBEEF, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_BOTH, 20'h00012, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_BOTH, 20'h00000, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_BOTH, 20'h00000, 16'h0000, 16'hBEEF, 1, 0, 0));
      vecs.push_back(mk(RD_BOTH, 20'h00000, 16'h0000, 16'hBEEF, 1, 0, 0));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 0));
      // byte lanes
      vecs.push_back(mk(WR_BOTH, 20'h00040, 16'h1234, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(WR_UP,   20'h00040, 16'hABCD, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_BOTH, 20'h00040, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_BOTH, 20'h00040, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_BOTH, 20'h00040, 16'h0000, 16'hAB34, 1, 0, 0));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_LO,   20'h00040, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_LO,   20'h00040, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_LO,   20'h00040, 16'h0000, 16'h0034, 1, 0, 0));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 0));
      // upper address bits alias
      vecs.push_back(mk(WR_BOTH, 20'h00105, 16'h5A5A, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_BOTH, 20'hFFF05, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_BOTH, 20'hFFF05, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_BOTH, 20'hFFF05, 16'h0000, 16'h5A5A, 1, 0, 0));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 0));
      // both lanes disabled: write is a no-op, read returns zero with valid
      vecs.push_back(mk(WR_NONE, 20'h00040, 16'hFFFF, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_BOTH, 20'h00040, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_BOTH, 20'h00040, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_BOTH, 20'h00040, 16'h0000, 16'hAB34, 1, 0, 0));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_NONE, 20'h00040, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_NONE, 20'h00040, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(RD_NONE, 20'h00040, 16'h0000, 16'h0000, 1, 0, 0));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 0));
      // three conflicts, array unchanged
      vecs.push_back(mk(CONF,    20'h00040, 16'h0000, 16'h0000, 0, 1, 1));
      vecs.push_back(mk(CONF,    20'h00040, 16'h0000, 16'h0000, 0, 1, 2));
      vecs.push_back(mk(CONF,    20'h00040, 16'h0000, 16'h0000, 0, 1, 3));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(RD_BOTH, 20'h00040, 16'h0000, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(RD_BOTH, 20'h00040, 16'h0000, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(RD_BOTH, 20'h00040, 16'h0000, 16'hAB34, 1, 0, 3));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 3));
      // aborts in RD_WAIT: out_en release, then chip_en release
      vecs.push_back(mk(RD_BOTH, 20'h00040, 16'h0000, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(RD_REL,  20'h00040, 16'h0000, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(RD_REL,  20'h00040, 16'h0000, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(RD_BOTH, 20'h00040, 16'h0000, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(NOP,     20'h00040, 16'h0000, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(NOP,     20'h00040, 16'h0000, 16'h0000, 0, 0, 3));
      // held write strobe: only the first cycle commits
      vecs.push_back(mk(WR_BOTH, 20'h00077, 16'h1111, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(WR_BOTH, 20'h00077, 16'h2222, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(WR_BOTH, 20'h00077, 16'h3333, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(WR_BOTH, 20'h00077, 16'h4444, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(RD_BOTH, 20'h00077, 16'h0000, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(RD_BOTH, 20'h00077, 16'h0000, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(RD_BOTH, 20'h00077, 16'h0000, 16'h1111, 1, 0, 3));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 3));
      // conflict while driving read data, then while holding a write
      vecs.push_back(mk(RD_BOTH, 20'h00040, 16'h0000, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(RD_BOTH, 20'h00040, 16'h0000, 16'h0000, 0, 0, 3));
      vecs.push_back(mk(RD_BOTH, 20'h00040, 16'h0000, 16'hAB34, 1, 0, 3));
      vecs.push_back(mk(CONF,    20'h00040, 16'h0000, 16'h0000, 0, 1, 4));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 4));
      vecs.push_back(mk(WR_BOTH, 20'h00078, 16'h1111, 16'h0000, 0, 0, 4));
      vecs.push_back(mk(CONF,    20'h00078, 16'h2222, 16'h0000, 0, 1, 5));
      vecs.push_back(mk(NOP,     20'h00000, 16'h0000, 16'h0000, 0, 0, 5));

      rst = 1'b1;
      drive(NOP, 20'h0, 16'h0);
      step();
      step();
      chk_all("reset", 16'h0000, 1'b0, 1'b0, 8'h00);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].strb, vecs[i].addr, vecs[i].din);
         step();
         chk_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].valid,
                 vecs[i].conf, vecs[i].err);
      end

      // 300 conflicts saturate the counter
      for (int k = 0; k < 300; k++) begin
         drive(CONF, 20'h00040, 16'h0000);
         step();
      end
      chk_all("sat last", 16'h0000, 1'b0, 1'b1, 8'hFF);
      drive(NOP, 20'h0, 16'h0);
      step();
      chk_all("sat idle", 16'h0000, 1'b0, 1'b0, 8'hFF);

      // reset while driving read data, then write straight out of reset
      for (int k = 0; k < 3; k++) begin
         drive(RD_BOTH, 20'h00040, 16'h0000);
         step();
      end
      chk_all("pre-reset drive", 16'hAB34, 1'b1, 1'b0, 8'hFF);
      rst = 1'b1;
      step();
      chk_all("reset in drive", 16'h0000, 1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      drive(WR_BOTH, 20'h00033, 16'h0C0C);
      step();
      drive(NOP, 20'h0, 16'h0);
      step();
      for (int k = 0; k < 3; k++) begin
         drive(RD_BOTH, 20'h00033, 16'h0000);
         step();
      end
      chk_all("post-reset write", 16'h0C0C, 1'b1, 1'b0, 8'h00);
      drive(NOP, 20'h0, 16'h0);
      step();
      chk_all("post-reset idle", 16'h0000, 1'b0, 1'b0, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
